// File: rtl/uart_pkg.sv
// uart_pkg: transmit frame states and tx_mux select codes shared across the UART.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
  localparam logic [1:0] SEL_IDLE   = 2'b00;
  localparam logic [1:0] SEL_START  = 2'b01;
  localparam logic [1:0] SEL_DATA   = 2'b10;
  localparam logic [1:0] SEL_PARITY = 2'b11;
  function automatic logic [1:0] sel_of(tx_state_t s);
    return s == START ? SEL_START : s == DATA ? SEL_DATA : s == PARITY ? SEL_PARITY : SEL_IDLE;
  endfunction
endpackage

// File: rtl/uart_tx_ctrl_if.sv
// uart_tx_ctrl_if: request side and tx_mux side of the transmit sequencer.
interface uart_tx_ctrl_if #(parameter int DATA_W = 8);
  logic              tx_start;
  logic [DATA_W-1:0] tx_data;
  logic [1:0]        sel;
  logic              data_bit;
  logic              parity_bit;
  logic              tx_busy;
  logic              tx_done;
  modport master (output tx_start, tx_data, input sel, data_bit, parity_bit, tx_busy, tx_done);
  modport slave  (input tx_start, tx_data, output sel, data_bit, parity_bit, tx_busy, tx_done);
endinterface

// File: rtl/uart_tx_ctrl_baud_cnt.sv
// baud_cnt: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit period.
module baud_cnt #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  output logic bit_end_o
);
  localparam int W = $clog2(CLKS_PER_BIT);
  logic [W-1:0] cnt_q;
  assign bit_end_o = cnt_q == W'(CLKS_PER_BIT - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= (clr_i || bit_end_o) ? '0 : cnt_q + 1'b1;
endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: frame FSM, baud timing and shift register driving tx_mux's select/data/parity.
module uart_tx_ctrl #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int DATA_W     = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input logic           clk,
  input logic           rst_n,
  uart_tx_ctrl_if.slave bus
);
  import uart_pkg::*;
  localparam int CPB = CLK_FREQ / BAUD;
  localparam int IW  = $clog2(DATA_W);
  localparam logic [IW-1:0] LAST = IW'(DATA_W - 1);
  tx_state_t state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [IW-1:0] idx_q, idx_d;
  logic par_q, par_d, busy_q, done_q, bit_end, clr;
  logic [1:0] sel_q;
  // the counter is held clear while idle so START gets a full bit period
  assign clr = state_q == IDLE || state_d != state_q;
  baud_cnt #(.CLKS_PER_BIT(CPB)) u_baud (.clk, .rst_n, .clr_i(clr), .bit_end_o(bit_end));
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    par_d   = par_q;
    unique case (state_q)
      IDLE: if (bus.tx_start) begin
        state_d = START;
        shreg_d = bus.tx_data;
        par_d   = ^bus.tx_data ^ 1'(PARITY_ODD);
      end
      START: if (bit_end) begin
        state_d = DATA;
        idx_d   = '0;
      end
      DATA: if (bit_end) begin
        shreg_d = shreg_q >> 1;
        idx_d   = idx_q + 1'b1;
        state_d = idx_q == LAST ? (PARITY_EN != 0 ? PARITY : STOP) : DATA;
      end
      PARITY: state_d = bit_end ? STOP : PARITY;
      STOP:   state_d = bit_end ? IDLE : STOP;
      default: state_d = IDLE;
    endcase
  end
  // outputs are registered from next-state values so they line up with state_q
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      par_q   <= 1'b0;
      sel_q   <= SEL_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      par_q   <= par_d;
      sel_q   <= sel_of(state_d);
      busy_q  <= state_d != IDLE;
      done_q  <= state_q == STOP && bit_end;
    end
  assign bus.sel        = sel_q;
  assign bus.data_bit   = shreg_q[0];
  assign bus.parity_bit = par_q;
  assign bus.tx_busy    = busy_q;
  assign bus.tx_done    = done_q;
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: checks frames against a bit-list line model and a mid-bit sampling UART receiver.
module tb_uart_tx_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [2:0] start_v = '0;
  logic [7:0] din [3];
  logic [1:0] sel_v [3];
  logic [2:0] line_v, busy_v, done_v, par_v, dbit_v;
  int total_n = 0;
  int bad_n = 0;
  function automatic logic mux_line(input logic [1:0] s, input logic d, input logic p);
    return s == 2'b00 ? 1'b1 : s == 2'b01 ? 1'b0 : s == 2'b10 ? d : p;
  endfunction
  uart_tx_ctrl_if #(.DATA_W(8)) ifa ();
  uart_tx_ctrl_if #(.DATA_W(8)) ifb ();
  uart_tx_ctrl_if #(.DATA_W(8)) ifc ();
  uart_tx_ctrl #(.CLK_FREQ(8), .BAUD(1), .DATA_W(8), .PARITY_EN(1), .PARITY_ODD(0))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  uart_tx_ctrl #(.CLK_FREQ(8), .BAUD(1), .DATA_W(8), .PARITY_EN(0), .PARITY_ODD(1))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
  uart_tx_ctrl #(.CLK_FREQ(50_000_000), .BAUD(115_200), .DATA_W(8), .PARITY_EN(1), .PARITY_ODD(0))
    dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));
  assign ifa.tx_start = start_v[0];
  assign ifb.tx_start = start_v[1];
  assign ifc.tx_start = start_v[2];
  assign ifa.tx_data = din[0];
  assign ifb.tx_data = din[1];
  assign ifc.tx_data = din[2];
  assign sel_v[0] = ifa.sel;
  assign sel_v[1] = ifb.sel;
  assign sel_v[2] = ifc.sel;
  assign line_v = {mux_line(ifc.sel, ifc.data_bit, ifc.parity_bit),
                   mux_line(ifb.sel, ifb.data_bit, ifb.parity_bit),
                   mux_line(ifa.sel, ifa.data_bit, ifa.parity_bit)};
  assign busy_v = {ifc.tx_busy, ifb.tx_busy, ifa.tx_busy};
  assign done_v = {ifc.tx_done, ifb.tx_done, ifa.tx_done};
  assign par_v  = {ifc.parity_bit, ifb.parity_bit, ifa.parity_bit};
  assign dbit_v = {ifc.data_bit, ifb.data_bit, ifa.data_bit};

  task automatic chk(input string name, input int act, input int exp);
    total_n++;
    if (act != exp) begin
      bad_n++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drives one request at 8 clocks/bit and compares every cycle with the ideal frame.
  task automatic run_frame(input int k, input logic [7:0] d, input bit pen, input bit podd,
                           input bit hold, input int inj, input string tag,
                           output logic par, output int done_at);
    logic bits[$];
    int tot, lerr, berr, derr, s11;
    bits = {1'b0};
    for (int b = 0; b < 8; b++) bits.push_back(d[b]);
    if (pen) bits.push_back(^d ^ podd);
    bits.push_back(1'b1);
    tot = bits.size() * 8;
    lerr = 0; berr = 0; derr = 0; s11 = 0; done_at = -1; par = 1'b0;
    start_v[k] = 1'b1;
    din[k] = d;
    for (int i = 0; i <= tot; i++) begin
      @(negedge clk);
      if (i == 0) par = par_v[k];
      if (i < tot && line_v[k] !== bits[i / 8]) lerr++;
      if (busy_v[k] !== (i < tot)) berr++;
      if (done_v[k] === 1'b1) begin
        if (done_at < 0) done_at = i;
        if (i != tot) derr++;
      end else if (i == tot) derr++;
      if (sel_v[k] == 2'b11) s11++;
      if (i == 0 && !hold) start_v[k] = 1'b0;
      if (i == inj) begin
        start_v[k] = 1'b1;
        din[k] = 8'hFF;
      end
      if (i == inj + 1) start_v[k] = 1'b0;
    end
    chk({tag, " line"}, lerr, 0);
    chk({tag, " busy"}, berr, 0);
    chk({tag, " done"}, derr, 0);
    if (!pen) chk({tag, " sel11"}, s11, 0);
  endtask

  task automatic idle_check(input int k, input int n, input string tag);
    int err = 0;
    repeat (n) begin
      @(negedge clk);
      if (line_v[k] !== 1'b1 || busy_v[k] !== 1'b0 || done_v[k] !== 1'b0) err++;
    end
    chk({tag, " idle"}, err, 0);
  endtask

  // Independent receiver: find the start edge, then sample each bit at its centre.
  task automatic rx_byte(output logic [7:0] b, output int ferr, output int perr, output int tmo);
    int w = 0;
    b = '0; ferr = 0; perr = 0; tmo = 0;
    while (line_v[2] !== 1'b0 && w < 1000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 1000) begin
      tmo = 1;
      return;
    end
    repeat (217) @(negedge clk);
    if (line_v[2] !== 1'b0) ferr++;
    for (int i = 0; i < 8; i++) begin
      repeat (434) @(negedge clk);
      b[i] = line_v[2];
    end
    repeat (434) @(negedge clk);
    if (line_v[2] !== ^b) perr++;
    repeat (434) @(negedge clk);
    if (line_v[2] !== 1'b1) ferr++;
  endtask

  typedef struct {
    int k;
    logic [7:0] d;
    bit pen;
    bit podd;
    logic exp_par;
    int exp_len;
  } vec_t;
  vec_t tbl [8];

  initial begin
    logic p;
    logic [7:0] d, rb;
    int da, fe, pe, to, w;
    tbl[0] = '{0, 8'hA5, 1'b1, 1'b0, 1'b0, 88};
    tbl[1] = '{0, 8'h00, 1'b1, 1'b0, 1'b0, 88};
    tbl[2] = '{0, 8'hFF, 1'b1, 1'b0, 1'b0, 88};
    tbl[3] = '{0, 8'h01, 1'b1, 1'b0, 1'b1, 88};
    tbl[4] = '{0, 8'h7F, 1'b1, 1'b0, 1'b1, 88};
    tbl[5] = '{1, 8'h00, 1'b0, 1'b1, 1'b1, 80};
    tbl[6] = '{1, 8'h80, 1'b0, 1'b1, 1'b0, 80};
    tbl[7] = '{1, 8'hFF, 1'b0, 1'b1, 1'b1, 80};
    for (int k = 0; k < 3; k++) din[k] = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst sel", int'(sel_v[0]), 0);
    chk("rst data_bit", int'(dbit_v[0]), 0);
    chk("rst parity_bit", int'(par_v[0]), 0);
    chk("rst busy", int'(busy_v[0]), 0);
    chk("rst done", int'(done_v[0]), 0);
    rst_n = 1'b1;
    idle_check(0, 4, "after rst");

    start_v[0] = 1'b1;
    din[0] = 8'hC3;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (30) @(negedge clk);
    chk("mid sel is data", int'(sel_v[0]), 2);
    #1 rst_n = 1'b0;
    #1;
    chk("abort sel", int'(sel_v[0]), 0);
    chk("abort busy", int'(busy_v[0]), 0);
    chk("abort done", int'(done_v[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_check(0, 24, "post abort");

    for (int i = 0; i < 8; i++) begin
      run_frame(tbl[i].k, tbl[i].d, tbl[i].pen, tbl[i].podd, 1'b0, -5,
                $sformatf("tbl%0d", i), p, da);
      chk($sformatf("tbl%0d parity_bit", i), int'(p), int'(tbl[i].exp_par));
      chk($sformatf("tbl%0d length", i), da, tbl[i].exp_len);
    end

    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom);
      run_frame(0, d, 1'b1, 1'b0, 1'b0, -5, $sformatf("rnd%0d", i), p, da);
      chk($sformatf("rnd%0d parity_bit", i), int'(p), int'(^d));
      chk($sformatf("rnd%0d length", i), da, 88);
    end

    run_frame(0, 8'h3C, 1'b1, 1'b0, 1'b0, 20, "busy ign", p, da);
    chk("busy ign length", da, 88);
    idle_check(0, 24, "busy ign");

    run_frame(0, 8'h55, 1'b1, 1'b0, 1'b1, -5, "b2b first", p, da);
    run_frame(0, 8'hAA, 1'b1, 1'b0, 1'b0, -5, "b2b second", p, da);
    chk("b2b second length", da, 88);
    idle_check(0, 8, "b2b");

    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom);
      start_v[2] = 1'b1;
      din[2] = d;
      @(negedge clk);
      start_v[2] = 1'b0;
      rx_byte(rb, fe, pe, to);
      chk($sformatf("rx%0d timeout", i), to, 0);
      chk($sformatf("rx%0d byte", i), int'(rb), int'(d));
      chk($sformatf("rx%0d framing", i), fe, 0);
      chk($sformatf("rx%0d parity", i), pe, 0);
      w = 0;
      while (done_v[2] !== 1'b1 && w < 1000) begin
        @(negedge clk);
        w++;
      end
      chk($sformatf("rx%0d done seen", i), int'(w < 1000), 1);
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end
endmodule
